dcmi_irq_ctrl: RTL

//  Parametrised DCMI interrupt controller for NUM_SRC sources; successor to the fixed 5-source status block.

---
 rtl/dcmi_irq_ctrl_pkg.sv | 22 ++
 rtl/dcmi_irq_ctrl_if.sv | 28 ++
 rtl/dcmi_irq_ctrl_bit.sv | 53 +++++
 rtl/dcmi_irq_ctrl.sv | 62 ++++++
 4 files changed

// File: rtl/dcmi_irq_ctrl_pkg.sv
// Shared types and constants for the DCMI interrupt controller.
// Optional overrun tracking is enabled by defining DCMI_IRQ_OVR_EN.
package dcmi_irq_ctrl_pkg;

    typedef enum logic {
        IRQ_MODE_EDGE  = 1'b0,
        IRQ_MODE_LEVEL = 1'b1
    } irq_mode_e;

    // Default source positions of the legacy five-source status block
    localparam int unsigned SRC_FE    = 0;
    localparam int unsigned SRC_OVFL  = 1;
    localparam int unsigned SRC_ERR   = 2;
    localparam int unsigned SRC_VSYNC = 3;
    localparam int unsigned SRC_LINE  = 4;

    // Sticky flag update where a set request beats a clear in the same cycle
    function automatic logic flag_next(input logic set, input logic clr, input logic cur);
        return set ? 1'b1 : (clr ? 1'b0 : cur);
    endfunction

endpackage

// File: rtl/dcmi_irq_ctrl_if.sv
// Register-file / event-source side of the DCMI interrupt controller.
interface dcmi_irq_ctrl_if #(
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned HOLD_W  = 8
) ();

    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] src_mode;
    logic [NUM_SRC-1:0] sw_set;
    logic [NUM_SRC-1:0] dcmi_ier;
    logic [NUM_SRC-1:0] dcmi_icr;
    logic [HOLD_W-1:0]  holdoff_cfg;
    logic [NUM_SRC-1:0] dcmi_ris;
    logic [NUM_SRC-1:0] dcmi_mis;
    logic [NUM_SRC-1:0] dcmi_ovr;
    logic               dcmi_irq;

    modport master (
        output src_in, src_mode, sw_set, dcmi_ier, dcmi_icr, holdoff_cfg,
        input  dcmi_ris, dcmi_mis, dcmi_ovr, dcmi_irq
    );

    modport slave (
        input  src_in, src_mode, sw_set, dcmi_ier, dcmi_icr, holdoff_cfg,
        output dcmi_ris, dcmi_mis, dcmi_ovr, dcmi_irq
    );

endinterface

// File: rtl/dcmi_irq_ctrl_bit.sv
// One interrupt source slice: input history, event detect, raw status, overrun.
// Overrun flop exists only when DCMI_IRQ_OVR_EN is defined.
module dcmi_irq_bit
    import dcmi_irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src_in,
    input  logic src_mode,
    input  logic sw_set,
    input  logic icr,
    output logic ris,
    output logic ovr
);

    logic src_q;
    logic evt;

    // src_q tracks in both modes so a level->edge switch sees no false edge
    always_comb begin
        evt = sw_set;
        if (irq_mode_e'(src_mode) == IRQ_MODE_LEVEL)
            evt = evt | src_in;
        else
            evt = evt | (src_in & ~src_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= 1'b0;
            ris   <= 1'b0;
        end else begin
            src_q <= src_in;
            ris   <= flag_next(evt, icr, ris);
        end
    end

`ifdef DCMI_IRQ_OVR_EN
    logic ovr_q;

    always_ff @(posedge clk) begin
        if (rst)
            ovr_q <= 1'b0;
        else
            ovr_q <= flag_next(evt & ris & ~icr, icr, ovr_q);
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: rtl/dcmi_irq_ctrl.sv
// DCMI interrupt controller: NUM_SRC source slices, masked status and a registered
// IRQ with re-assert holdoff. Define DCMI_IRQ_OVR_EN to enable overrun flags.
module dcmi_irq_ctrl
    import dcmi_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned HOLD_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    dcmi_irq_ctrl_if.slave  bus
);

    logic [NUM_SRC-1:0] ris;
    logic [NUM_SRC-1:0] ovr;
    logic [NUM_SRC-1:0] mis;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic               irq;
    logic               irq_nxt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        dcmi_irq_bit u_bit (
            .clk      (clk),
            .rst      (rst),
            .src_in   (bus.src_in[i]),
            .src_mode (bus.src_mode[i]),
            .sw_set   (bus.sw_set[i]),
            .icr      (bus.dcmi_icr[i]),
            .ris      (ris[i]),
            .ovr      (ovr[i])
        );
    end

    assign mis = ris & bus.dcmi_ier;

    // Holdoff loads on the IRQ falling edge; cfg is not looked at otherwise
    always_comb begin
        irq_nxt  = (|mis) && (hold_cnt == '0);
        hold_nxt = hold_cnt;
        if (irq && !irq_nxt)
            hold_nxt = bus.holdoff_cfg;
        else if (hold_cnt != '0)
            hold_nxt = hold_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq      <= 1'b0;
            hold_cnt <= '0;
        end else begin
            irq      <= irq_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign bus.dcmi_ris = ris;
    assign bus.dcmi_mis = mis;
    assign bus.dcmi_ovr = ovr;
    assign bus.dcmi_irq = irq;

endmodule
